ysyx_23060201_wbu: RTL and testbench

Writeback unit for the ysyx_23060201 core. It accepts register-write results from the EXU and the LSU over valid/ready handshakes and arbitrates round-robin between them. It drives the general-purpose register file's single write port from a registered output stage. It also keeps a per-register pending-write scoreboard so the IDU can detect read-after-write hazards and stall.

---
 rtl/ysyx_23060201_wbu.sv | 126 ++++++++++++
 tb/tb_ysyx_23060201_wbu.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060201_wbu.sv
// ============================================================================
// Module   : ysyx_23060201_wbu
// Brief    : Writeback unit. Round-robin EXU/LSU arbiter, registered GPR write
//            port and per-register pending-write scoreboard for RAW hazards.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_23060201_wbu #(
    parameter int GPR_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_valid,
    input  logic [GPR_ADDR_WIDTH-1:0]    issue_rd,
    output logic                         issue_ready,
    input  logic                         exu_valid,
    output logic                         exu_ready,
    input  logic [GPR_ADDR_WIDTH-1:0]    exu_rd,
    input  logic [DATA_WIDTH-1:0]        exu_data,
    input  logic                         lsu_valid,
    output logic                         lsu_ready,
    input  logic [GPR_ADDR_WIDTH-1:0]    lsu_rd,
    input  logic [DATA_WIDTH-1:0]        lsu_data,
    output logic                         gpr_wen,
    output logic [GPR_ADDR_WIDTH-1:0]    gpr_waddr,
    output logic [DATA_WIDTH-1:0]        gpr_wdata,
    output logic [2**GPR_ADDR_WIDTH-1:0] busy_vec,
    output logic                         sb_err
);

    localparam int c_NREG = 2**GPR_ADDR_WIDTH;

    logic [1:0]        w_cnt [c_NREG];
    logic [c_NREG-1:0] w_uflow;
    logic              w_issue_fire;
    logic              r_last_lsu;
    logic [7:0]        r_wdog;
    logic              r_sb_err;

    assign issue_ready  = (issue_rd == '0) || (w_cnt[issue_rd] != 2'd3);
    assign w_issue_fire = issue_valid && issue_ready && (issue_rd != '0);

    // Ties go to whichever source was not granted last.
    assign exu_ready = !rst && exu_valid && (!lsu_valid ||  r_last_lsu);
    assign lsu_ready = !rst && lsu_valid && (!exu_valid || !r_last_lsu);

    generate
        for (genvar gi = 0; gi < c_NREG; gi++) begin : g_sb
            if (gi == 0) begin : g_zero
                assign w_cnt[gi]   = 2'd0;
                assign w_uflow[gi] = 1'b0;
                assign busy_vec[gi] = 1'b0;
            end else begin : g_reg
                logic [1:0] r_cnt;
                logic       w_inc;
                logic       w_dec;

                assign w_inc = w_issue_fire && (issue_rd == GPR_ADDR_WIDTH'(gi));
                assign w_dec = gpr_wen && (gpr_waddr == GPR_ADDR_WIDTH'(gi));
                assign w_uflow[gi]  = w_dec && !w_inc && (r_cnt == 2'd0);
                assign w_cnt[gi]    = r_cnt;
                assign busy_vec[gi] = (r_cnt != 2'd0);

                // Simultaneous issue and retire cancel out.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_cnt <= 2'd0;
                    end else if (w_inc && !w_dec) begin
                        r_cnt <= r_cnt + 2'd1;
                    end else if (w_dec && !w_inc && (r_cnt != 2'd0)) begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            gpr_wen    <= 1'b0;
            gpr_waddr  <= '0;
            gpr_wdata  <= '0;
            r_last_lsu <= 1'b0;
        end else if (exu_ready) begin
            gpr_wen    <= (exu_rd != '0);
            gpr_waddr  <= exu_rd;
            gpr_wdata  <= exu_data;
            r_last_lsu <= 1'b0;
        end else if (lsu_ready) begin
            gpr_wen    <= (lsu_rd != '0);
            gpr_waddr  <= lsu_rd;
            gpr_wdata  <= lsu_data;
            r_last_lsu <= 1'b1;
        end else begin
            gpr_wen    <= 1'b0;
        end
    end

    // Deadlock watchdog: flags an issue stalled for more than 255 cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog   <= 8'd0;
            r_sb_err <= 1'b0;
        end else begin
            if (|w_uflow) begin
                r_sb_err <= 1'b1;
            end
            if (issue_ready) begin
                r_wdog <= 8'd0;
            end else if (issue_valid) begin
                if (r_wdog == 8'hFF) begin
                    r_sb_err <= 1'b1;
                end else begin
                    r_wdog <= r_wdog + 8'd1;
                end
            end
        end
    end

    assign sb_err = r_sb_err;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060201_wbu.sv
// ============================================================================
// Module   : tb_ysyx_23060201_wbu
// Brief    : Directed self-checking bench for the writeback unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_23060201_wbu;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        exu_valid;
    logic        exu_ready;
    logic [4:0]  exu_rd;
    logic [31:0] exu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic [31:0] busy_vec;
    logic        sb_err;

    int n_chk;
    int n_pass;

    ysyx_23060201_wbu #(
        .GPR_ADDR_WIDTH (5),
        .DATA_WIDTH     (32)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .exu_valid   (exu_valid),
        .exu_ready   (exu_ready),
        .exu_rd      (exu_rd),
        .exu_data    (exu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .gpr_wen     (gpr_wen),
        .gpr_waddr   (gpr_waddr),
        .gpr_wdata   (gpr_wdata),
        .busy_vec    (busy_vec),
        .sb_err      (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid = 1'b1;
        issue_rd    = rd;
        tick();
        issue_valid = 1'b0;
    endtask

    initial begin
        int e;
        int l;
        int seq [8];
        logic exp_lsu;
        logic [31:0] exp_data;

        n_chk = 0;
        n_pass = 0;
        seq = '{9, 1, 10, 2, 11, 3, 12, 4};

        // Reset, with both sources valid to prove readies are masked
        rst = 1'b1;
        issue_valid = 1'b0; issue_rd = 5'd0;
        exu_valid = 1'b1; exu_rd = 5'd1; exu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
        tick();
        tick();
        chk("rst_exu_ready", exu_ready, 0);
        chk("rst_lsu_ready", lsu_ready, 0);
        chk("rst_wen", gpr_wen, 0);
        chk("rst_waddr", gpr_waddr, 0);
        chk("rst_wdata", gpr_wdata, 0);
        chk("rst_busy", busy_vec, 0);
        chk("rst_sb_err", sb_err, 0);
        chk("rst_issue_ready", issue_ready, 1);
        exu_valid = 1'b0; lsu_valid = 1'b0; rst = 1'b0;
        tick();

        // Basic issue -> EXU writeback -> retire
        issue(5'd5);
        chk("t1_busy5_set", busy_vec[5], 1);
        exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF;
        #1;
        chk("t1_exu_ready", exu_ready, 1);
        chk("t1_lsu_ready", lsu_ready, 0);
        tick();
        exu_valid = 1'b0;
        chk("t1_wen", gpr_wen, 1);
        chk("t1_waddr", gpr_waddr, 5);
        chk("t1_wdata", gpr_wdata, 32'hDEADBEEF);
        chk("t1_busy5_held", busy_vec[5], 1);
        tick();
        chk("t1_busy5_clr", busy_vec[5], 0);
        chk("t1_wen_off", gpr_wen, 0);
        chk("t1_waddr_hold", gpr_waddr, 5);

        // Round-robin: last grant was EXU, so LSU wins first tie
        for (int r = 1; r <= 4; r++) issue(5'(r));
        for (int r = 9; r <= 12; r++) issue(5'(r));
        chk("t2_busy_pre", busy_vec, 32'h00001E1E);
        e = 1; l = 9;
        for (int k = 0; k < 8; k++) begin
            exu_valid = (e <= 4); exu_rd = e[4:0]; exu_data = 32'h100 + e;
            lsu_valid = (l <= 12); lsu_rd = l[4:0]; lsu_data = 32'h200 + l;
            #1;
            exp_lsu = (k % 2 == 0);
            chk("t2_exu_ready", exu_ready, !exp_lsu);
            chk("t2_lsu_ready", lsu_ready, exp_lsu);
            tick();
            exp_data = (seq[k] >= 9) ? (32'h200 + seq[k]) : (32'h100 + seq[k]);
            chk("t2_waddr", gpr_waddr, seq[k]);
            chk("t2_wdata", gpr_wdata, exp_data);
            if (exp_lsu) l++; else e++;
        end
        exu_valid = 1'b0; lsu_valid = 1'b0;
        tick();
        chk("t2_busy_post", busy_vec, 0);

        // Counter saturation on rd 7
        issue(5'd7); issue(5'd7); issue(5'd7);
        issue_valid = 1'b1; issue_rd = 5'd7;
        #1;
        chk("t3_issue_blocked", issue_ready, 0);
        tick();
        issue_valid = 1'b0;
        chk("t3_busy7_full", busy_vec[7], 1);
        exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h77;
        tick();
        exu_valid = 1'b0;
        tick();
        chk("t3_issue_reopen", issue_ready, 1);
        chk("t3_busy7_after1", busy_vec[7], 1);
        exu_valid = 1'b1;
        tick();
        tick();
        exu_valid = 1'b0;
        chk("t3_busy7_after2", busy_vec[7], 1);
        tick();
        chk("t3_busy7_after3", busy_vec[7], 0);

        // Issue and retire of rd 3 in the same cycle
        issue(5'd3);
        exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'h33;
        tick();
        exu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd3;
        #1;
        chk("t4_wen", gpr_wen, 1);
        tick();
        issue_valid = 1'b0;
        chk("t4_busy3_same", busy_vec[3], 1);
        exu_valid = 1'b1;
        tick();
        exu_valid = 1'b0;
        tick();
        chk("t4_busy3_clr", busy_vec[3], 0);
        chk("t4_sb_err", sb_err, 0);

        // Write to x0 is accepted but suppressed
        exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'h1234;
        #1;
        chk("t5_exu_ready", exu_ready, 1);
        tick();
        exu_valid = 1'b0;
        chk("t5_wen", gpr_wen, 0);
        chk("t5_wdata", gpr_wdata, 32'h1234);
        chk("t5_busy", busy_vec, 0);
        tick();
        chk("t5_sb_err", sb_err, 0);

        // Underflow retire to rd 8 sets sticky error
        exu_valid = 1'b1; exu_rd = 5'd8; exu_data = 32'h88;
        tick();
        exu_valid = 1'b0;
        chk("t6_err_pre", sb_err, 0);
        chk("t6_wen_x8", gpr_wen, 1);
        tick();
        chk("t6_err_set", sb_err, 1);
        tick();
        chk("t6_err_sticky", sb_err, 1);

        // Mid-stream reset cancels pending write and counts
        issue(5'd6);
        exu_valid = 1'b1; exu_rd = 5'd6; exu_data = 32'h66;
        tick();
        exu_valid = 1'b0;
        chk("t6_wen_pending", gpr_wen, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_wen", gpr_wen, 0);
        chk("t6_rst_busy", busy_vec, 0);
        chk("t6_rst_err", sb_err, 0);

        // First tie after reset goes to LSU
        issue(5'd13); issue(5'd14);
        exu_valid = 1'b1; exu_rd = 5'd13; exu_data = 32'hD;
        lsu_valid = 1'b1; lsu_rd = 5'd14; lsu_data = 32'hE;
        #1;
        chk("t7_lsu_first", lsu_ready, 1);
        chk("t7_exu_wait", exu_ready, 0);
        tick();
        lsu_valid = 1'b0;
        chk("t7_waddr14", gpr_waddr, 14);
        tick();
        exu_valid = 1'b0;
        chk("t7_waddr13", gpr_waddr, 13);
        tick();
        chk("t7_busy", busy_vec, 0);

        // Watchdog: 255 stalled cycles tolerated, the 256th flags
        issue(5'd2); issue(5'd2); issue(5'd2);
        issue_valid = 1'b1; issue_rd = 5'd2;
        repeat (255) tick();
        chk("t8_wdog_255", sb_err, 0);
        tick();
        chk("t8_wdog_256", sb_err, 1);
        issue_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
